// File: rtl/xgmii_decoder.sv
// xgmii_decoder: receive-side 64b/66b decoder for a 10GBASE-R PCS.
//
// Takes descrambled 66-bit blocks as two 32-bit words (low word first, sync
// header sampled with the first word). Rebuilds the 64-bit block and decodes
// it to XGMII characters. Drives the result to the MAC as two 32-bit
// half-blocks on consecutive cycles.
//
// Ports:
//   i_clk            PCS RX clock
//   i_reset_n        synchronous, active-low reset
//   i_rx_data        descrambled block word; [7:0] of word 0 is the block type
//   i_rx_sync_hdr    sync header, sampled with word 0 only
//   i_rx_valid       i_rx_data valid this cycle
//   i_rx_block_start marks word 0 of a block (only when i_rx_valid=1)
//   o_xgmii_rxd      XGMII RX data, lane k = bits [8k+7:8k]
//   o_xgmii_rxc      XGMII RX control, 1 = control character
//   o_xgmii_valid    rxd/rxc carry a decoded half-block
//   o_decode_err     one-cycle pulse with the low half of an errored block
//   o_err_count      saturating count of errored blocks
module xgmii_decoder #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned CTRL_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned HDR_WIDTH     = 2,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [DATA_WIDTH-1:0]    i_rx_data,
    input  logic [HDR_WIDTH-1:0]     i_rx_sync_hdr,
    input  logic                     i_rx_valid,
    input  logic                     i_rx_block_start,
    output logic [DATA_WIDTH-1:0]    o_xgmii_rxd,
    output logic [CTRL_WIDTH-1:0]    o_xgmii_rxc,
    output logic                     o_xgmii_valid,
    output logic                     o_decode_err,
    output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

    localparam logic [7:0] XG_IDLE  = 8'h07;
    localparam logic [7:0] XG_START = 8'hFB;
    localparam logic [7:0] XG_TERM  = 8'hFD;
    localparam logic [7:0] XG_ERROR = 8'hFE;

    localparam logic [DATA_WIDTH-1:0]    IDLE_WORD = {CTRL_WIDTH{XG_IDLE}};
    localparam logic [CTRL_WIDTH-1:0]    IDLE_CTRL = '1;
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX   = '1;

    // Returns {bad, xgmii_char} for a 7-bit 10GBASE-R control code.
    function automatic logic [8:0] map_ctrl(input logic [6:0] code);
        logic [8:0] r;
        case (code)
            7'h00:   r = {1'b0, 8'h07};
            7'h06:   r = {1'b0, 8'h06};
            7'h1E:   r = {1'b0, 8'hFE};
            7'h2D:   r = {1'b0, 8'h1C};
            7'h33:   r = {1'b0, 8'h3C};
            7'h4B:   r = {1'b0, 8'h7C};
            7'h55:   r = {1'b0, 8'hBC};
            7'h66:   r = {1'b0, 8'hDC};
            7'h78:   r = {1'b0, 8'hF7};
            default: r = {1'b1, XG_ERROR};
        endcase
        return r;
    endfunction

    // Block assembly state
    logic [DATA_WIDTH-1:0] word0_q;
    logic [HDR_WIDTH-1:0]  hdr_q;
    logic                  phase_q;

    // Output state; hi_* holds lanes 4-7 until the cycle after the low half
    logic [DATA_WIDTH-1:0]    rxd_q;
    logic [CTRL_WIDTH-1:0]    rxc_q;
    logic                     valid_q;
    logic                     err_q;
    logic [ERR_CNT_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0]    hi_rxd_q;
    logic [CTRL_WIDTH-1:0]    hi_rxc_q;
    logic                     hi_pend_q;

    logic                       blk_done;
    logic [2*DATA_WIDTH-1:0]    blk;
    logic [2*DATA_WIDTH+7:0]    blk_ext;
    logic [2*DATA_WIDTH-1:0]    dec_rxd;
    logic [2*CTRL_WIDTH-1:0]    dec_rxc;
    logic                       dec_err;
    logic                       is_term;
    int                         term_k;
    logic [8:0]                 m;

    assign blk_done = i_rx_valid && !i_rx_block_start && phase_q;
    assign blk      = {i_rx_data, word0_q};
    // Zero-extended so the terminate loop can index byte i+1 for every lane
    assign blk_ext  = {8'h00, blk};

    always_comb begin
        dec_rxd = {2 * CTRL_WIDTH{XG_ERROR}};
        dec_rxc = '1;
        dec_err = 1'b1;
        is_term = 1'b0;
        term_k  = 0;
        m       = '0;
        if (hdr_q == 2'b01) begin
            dec_rxd = blk;
            dec_rxc = '0;
            dec_err = 1'b0;
        end else if (hdr_q == 2'b10) begin
            dec_err = 1'b0;
            case (blk[7:0])
                8'h1E: begin
                    for (int i = 0; i < 8; i++) begin
                        m = map_ctrl(blk[8 + 7 * i +: 7]);
                        dec_rxd[8 * i +: 8] = m[7:0];
                        dec_err = dec_err | m[8];
                    end
                end
                8'h78: begin
                    dec_rxd = {blk[63:8], XG_START};
                    dec_rxc = 8'h01;
                end
                8'h33: begin
                    for (int i = 0; i < 4; i++) begin
                        m = map_ctrl(blk[8 + 7 * i +: 7]);
                        dec_rxd[8 * i +: 8] = m[7:0];
                        dec_err = dec_err | m[8];
                    end
                    dec_rxd[63:32] = {blk[63:40], XG_START};
                    dec_rxc = 8'h1F;
                end
                8'h87: begin is_term = 1'b1; term_k = 0; end
                8'h99: begin is_term = 1'b1; term_k = 1; end
                8'hAA: begin is_term = 1'b1; term_k = 2; end
                8'hB4: begin is_term = 1'b1; term_k = 3; end
                8'hCC: begin is_term = 1'b1; term_k = 4; end
                8'hD2: begin is_term = 1'b1; term_k = 5; end
                8'hE1: begin is_term = 1'b1; term_k = 6; end
                8'hFF: begin is_term = 1'b1; term_k = 7; end
                default: dec_err = 1'b1;
            endcase
            if (is_term) begin
                for (int i = 0; i < 8; i++) begin
                    if (i < term_k) begin
                        dec_rxd[8 * i +: 8] = blk_ext[8 * (i + 1) +: 8];
                        dec_rxc[i] = 1'b0;
                    end else if (i == term_k) begin
                        dec_rxd[8 * i +: 8] = XG_TERM;
                    end else begin
                        dec_rxd[8 * i +: 8] = XG_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            word0_q   <= '0;
            hdr_q     <= '0;
            phase_q   <= 1'b0;
            rxd_q     <= IDLE_WORD;
            rxc_q     <= IDLE_CTRL;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            hi_rxd_q  <= IDLE_WORD;
            hi_rxc_q  <= IDLE_CTRL;
            hi_pend_q <= 1'b0;
        end else begin
            // A new word 0 always wins, dropping any pending one
            if (i_rx_valid) begin
                if (i_rx_block_start) begin
                    word0_q <= i_rx_data;
                    hdr_q   <= i_rx_sync_hdr;
                    phase_q <= 1'b1;
                end else if (phase_q) begin
                    phase_q <= 1'b0;
                end
            end

            if (blk_done) begin
                rxd_q     <= dec_rxd[DATA_WIDTH-1:0];
                rxc_q     <= dec_rxc[CTRL_WIDTH-1:0];
                valid_q   <= 1'b1;
                err_q     <= dec_err;
                hi_rxd_q  <= dec_rxd[2*DATA_WIDTH-1:DATA_WIDTH];
                hi_rxc_q  <= dec_rxc[2*CTRL_WIDTH-1:CTRL_WIDTH];
                hi_pend_q <= 1'b1;
                if (dec_err && (cnt_q != CNT_MAX)) begin
                    cnt_q <= cnt_q + ERR_CNT_WIDTH'(1);
                end
            end else if (hi_pend_q) begin
                rxd_q     <= hi_rxd_q;
                rxc_q     <= hi_rxc_q;
                valid_q   <= 1'b1;
                err_q     <= 1'b0;
                hi_pend_q <= 1'b0;
            end else begin
                rxd_q   <= IDLE_WORD;
                rxc_q   <= IDLE_CTRL;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end
        end
    end

    assign o_xgmii_rxd   = rxd_q;
    assign o_xgmii_rxc   = rxc_q;
    assign o_xgmii_valid = valid_q;
    assign o_decode_err  = err_q;
    assign o_err_count   = cnt_q;

endmodule
